// File: rtl/raw_capture_pkg.sv
// +--------------------------------------------------------------------------+
// | raw_capture_pkg : shared types and control/status field map (rev 1.0)    |
// +--------------------------------------------------------------------------+
`default_nettype none

package raw_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int ARM_BIT   = 0;
  localparam int FORCE_BIT = 1;
  localparam int CONT_BIT  = 2;
  localparam int ABORT_BIT = 3;
  localparam int DELAY_LSB = 16;
  localparam int DELAY_MSB = 31;

  localparam int STAT_ARMED    = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_DONE     = 2;
  localparam int STAT_CNT_LSB  = 8;
  localparam int STAT_ADDR_LSB = 16;

  function automatic logic [31:0] pack_status(state_e st, logic [7:0] cnt, logic [15:0] addr);
    logic [31:0] s;
    s = '0;
    s[STAT_ARMED] = (st == ST_ARMED);
    s[STAT_BUSY]  = (st == ST_DELAY) || (st == ST_CAPTURE);
    s[STAT_DONE]  = (st == ST_DONE);
    s[STAT_CNT_LSB +: 8]   = cnt;
    s[STAT_ADDR_LSB +: 16] = addr;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raw_capture_if.sv
// +--------------------------------------------------------------------------+
// | raw_capture_if : control/sample inputs and capture BRAM/status outputs   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface raw_capture_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
);
  logic [31:0]       ctrl_word;
  logic              sync_in;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [31:0]       status_word;
  logic [31:0]       trig_timestamp;

  modport master (
    output ctrl_word, sync_in, data_valid, data_in,
    input  bram_addr, bram_din, bram_we, status_word, trig_timestamp
  );

  modport slave (
    input  ctrl_word, sync_in, data_valid, data_in,
    output bram_addr, bram_din, bram_we, status_word, trig_timestamp
  );
endinterface

`default_nettype wire

// File: rtl/raw_capture_edge_det.sv
// +--------------------------------------------------------------------------+
// | raw_capture_edge_det : rising-edge detector for W control bits (rev 1.0) |
// +--------------------------------------------------------------------------+
`default_nettype none

module raw_capture_edge_det #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] bits_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= '0;
    else         prev_q <= bits_i;
  end

  assign rise_o = bits_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/raw_capture_ctrl.sv
// +--------------------------------------------------------------------------+
// | raw_capture_ctrl : raw ADC snapshot sequencer; optional trigger          |
// | timestamp under RAW_CAPTURE_TIMESTAMP_EN (rev 1.0)                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module raw_capture_ctrl
  import raw_capture_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic          user_clk,
  input  logic          user_rst_n,
  raw_capture_if.slave  cap_if
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dly_q, dly_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       status_q;

  logic [1:0]  ctrl_rise;
  logic        arm_edge, force_edge, cont, abort, trigger;
  logic [15:0] trig_delay;
  logic        ctrl_unused;

  raw_capture_edge_det #(.W(2)) u_edge_det (
    .clk_i  (user_clk),
    .rst_ni (user_rst_n),
    .bits_i (cap_if.ctrl_word[FORCE_BIT:ARM_BIT]),
    .rise_o (ctrl_rise)
  );

  assign arm_edge    = ctrl_rise[ARM_BIT];
  assign force_edge  = ctrl_rise[FORCE_BIT];
  assign cont        = cap_if.ctrl_word[CONT_BIT];
  assign abort       = cap_if.ctrl_word[ABORT_BIT];
  assign trig_delay  = cap_if.ctrl_word[DELAY_MSB:DELAY_LSB];
  assign trigger     = cap_if.sync_in | force_edge;
  assign ctrl_unused = ^cap_if.ctrl_word[DELAY_LSB-1:ABORT_BIT+1];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    // Abort wins over everything and leaves the address counter for software to read.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_edge) begin
            state_d = ST_ARMED;
            addr_d  = '0;
          end
        end
        ST_ARMED: begin
          if (trigger) begin
            if (trig_delay == 16'd0) begin
              state_d = ST_CAPTURE;
            end else begin
              state_d = ST_DELAY;
              dly_d   = trig_delay;
            end
          end
        end
        ST_DELAY: begin
          if (cap_if.data_valid) begin
            dly_d = dly_q - 16'd1;
            if (dly_q == 16'd1) state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (cap_if.data_valid) begin
            we_d   = 1'b1;
            addr_d = addr_q + ADDR_ONE;
            if (addr_q == ADDR_LAST) begin
              state_d = ST_DONE;
              cnt_d   = cnt_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (cont) begin
            state_d = ST_ARMED;
          end else if (arm_edge) begin
            state_d = ST_ARMED;
            addr_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      if (we_d) begin
        waddr_q <= addr_q;
        wdata_q <= cap_if.data_in;
      end
      status_q <= pack_status(state_q, cnt_q, 16'(addr_q));
    end
  end

  assign cap_if.bram_we     = we_q;
  assign cap_if.bram_addr   = waddr_q;
  assign cap_if.bram_din    = wdata_q;
  assign cap_if.status_word = status_q;

`ifdef RAW_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;
  logic        trig_accept;

  assign trig_accept = (state_q == ST_ARMED) && trigger && !abort;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trig_accept) ts_q <= ts_cnt_q;
    end
  end

  assign cap_if.trig_timestamp = ts_q;
`else
  assign cap_if.trig_timestamp = '0;
`endif

endmodule

`default_nettype wire
